// File: rtl/lcd_spi_sniffer.sv
// Receive side of a 3-wire write-only LCD serial link: oversamples SCLK/SDA/DC, rebuilds bytes,
// decodes CASET/RASET/RAMWR and emits addressed RGB565 pixel writes.
module lcd_spi_sniffer #(
  parameter int LCD_W        = 132,
  parameter int LCD_H        = 162,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        lcd_clk_in,
  input  logic        lcd_data_in,
  input  logic        lcd_dc_in,
  input  logic        lcd_rst_n_in,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_is_data,
  output logic        pix_valid,
  output logic [7:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        frame_done,
  output logic        sync_err
);

  localparam logic [2:0] ST_CMD    = 3'd0;
  localparam logic [2:0] ST_CASET  = 3'd1;
  localparam logic [2:0] ST_RASET  = 3'd2;
  localparam logic [2:0] ST_RAMWR  = 3'd3;
  localparam logic [2:0] ST_IGNORE = 3'd4;

  localparam logic [15:0] IDLE_LIM = 16'(IDLE_TIMEOUT);
  localparam logic [7:0]  XE_RST   = 8'(LCD_W - 1);
  localparam logic [7:0]  YE_RST   = 8'(LCD_H - 1);

  // Synchronizers; the third SCLK stage exists only for edge detection.
  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic sda_s1_q, sda_s2_q;
  logic dc_s1_q, dc_s2_q;
  logic rstn_s1_q, rstn_s2_q;

  logic sclk_rise;
  logic panel_rst;

  // Byte receiver state
  logic [6:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic        byte_valid_q, byte_valid_d;
  logic [7:0]  byte_data_q, byte_data_d;
  logic        byte_is_data_q, byte_is_data_d;
  logic        sync_err_q, sync_err_d;

  // Command decoder state
  logic [2:0]  state_q, state_d;
  logic [2:0]  param_q, param_d;
  logic [7:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [7:0]  x_q, x_d, y_q, y_d;
  logic        hi_flag_q, hi_flag_d;
  logic [7:0]  hi_byte_q, hi_byte_d;
  logic        pix_valid_q, pix_valid_d;
  logic [7:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic        frame_done_q, frame_done_d;

  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign panel_rst = ~rstn_s2_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_s3_q <= 1'b0;
      sda_s1_q  <= 1'b0;
      sda_s2_q  <= 1'b0;
      dc_s1_q   <= 1'b0;
      dc_s2_q   <= 1'b0;
      rstn_s1_q <= 1'b1;
      rstn_s2_q <= 1'b1;
    end else begin
      sclk_s1_q <= lcd_clk_in;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      sda_s1_q  <= lcd_data_in;
      sda_s2_q  <= sda_s1_q;
      dc_s1_q   <= lcd_dc_in;
      dc_s2_q   <= dc_s1_q;
      rstn_s1_q <= lcd_rst_n_in;
      rstn_s2_q <= rstn_s1_q;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    idle_cnt_d     = idle_cnt_q;
    byte_valid_d   = 1'b0;
    byte_data_d    = byte_data_q;
    byte_is_data_d = byte_is_data_q;
    sync_err_d     = 1'b0;

    if (sclk_rise) begin
      idle_cnt_d = '0;
      shift_d    = {shift_q[5:0], sda_s2_q};
      if (bit_cnt_q == 3'd7) begin
        bit_cnt_d      = '0;
        byte_valid_d   = 1'b1;
        byte_data_d    = {shift_q, sda_s2_q};
        byte_is_data_d = dc_s2_q;
      end else begin
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
    end else begin
      if (idle_cnt_q != IDLE_LIM) begin
        idle_cnt_d = idle_cnt_q + 16'd1;
      end
      if ((idle_cnt_q == IDLE_LIM) && (bit_cnt_q != 3'd0)) begin
        bit_cnt_d  = '0;
        sync_err_d = 1'b1;
      end
    end

    if (panel_rst) begin
      bit_cnt_d      = '0;
      byte_valid_d   = 1'b0;
      byte_data_d    = byte_data_q;
      byte_is_data_d = byte_is_data_q;
      sync_err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      idle_cnt_q     <= '0;
      byte_valid_q   <= 1'b0;
      byte_data_q    <= '0;
      byte_is_data_q <= 1'b0;
      sync_err_q     <= 1'b0;
    end else begin
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      idle_cnt_q     <= idle_cnt_d;
      byte_valid_q   <= byte_valid_d;
      byte_data_q    <= byte_data_d;
      byte_is_data_q <= byte_is_data_d;
      sync_err_q     <= sync_err_d;
    end
  end

  // Decoder consumes the registered byte, so pixels trail the low byte's strobe by one cycle.
  always_comb begin
    state_d      = state_q;
    param_d      = param_q;
    xs_d         = xs_q;
    xe_d         = xe_q;
    ys_d         = ys_q;
    ye_d         = ye_q;
    x_d          = x_q;
    y_d          = y_q;
    hi_flag_d    = hi_flag_q;
    hi_byte_d    = hi_byte_q;
    pix_valid_d  = 1'b0;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_data_d   = pix_data_q;
    frame_done_d = 1'b0;

    if (byte_valid_q) begin
      if (!byte_is_data_q) begin
        param_d = '0;
        case (byte_data_q)
          8'h2A: state_d = ST_CASET;
          8'h2B: state_d = ST_RASET;
          8'h2C: begin
            state_d   = ST_RAMWR;
            x_d       = xs_q;
            y_d       = ys_q;
            hi_flag_d = 1'b1;
          end
          default: state_d = ST_IGNORE;
        endcase
      end else begin
        case (state_q)
          ST_CASET: begin
            if (param_q == 3'd1) xs_d = byte_data_q;
            if (param_q == 3'd3) xe_d = byte_data_q;
            if (param_q != 3'd4) param_d = param_q + 3'd1;
          end
          ST_RASET: begin
            if (param_q == 3'd1) ys_d = byte_data_q;
            if (param_q == 3'd3) ye_d = byte_data_q;
            if (param_q != 3'd4) param_d = param_q + 3'd1;
          end
          ST_RAMWR: begin
            if (hi_flag_q) begin
              hi_byte_d = byte_data_q;
              hi_flag_d = 1'b0;
            end else begin
              pix_valid_d = 1'b1;
              pix_x_d     = x_q;
              pix_y_d     = y_q;
              pix_data_d  = {hi_byte_q, byte_data_q};
              hi_flag_d   = 1'b1;
              // ">=" rather than "==" makes an inverted window wrap on every pixel.
              if (x_q >= xe_q) begin
                x_d = xs_q;
                if (y_q >= ye_q) begin
                  y_d          = ys_q;
                  frame_done_d = 1'b1;
                end else begin
                  y_d = y_q + 8'd1;
                end
              end else begin
                x_d = x_q + 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end

    if (panel_rst) begin
      state_d      = ST_CMD;
      param_d      = '0;
      hi_flag_d    = 1'b0;
      xs_d         = '0;
      xe_d         = XE_RST;
      ys_d         = '0;
      ye_d         = YE_RST;
      pix_valid_d  = 1'b0;
      pix_x_d      = pix_x_q;
      pix_y_d      = pix_y_q;
      pix_data_d   = pix_data_q;
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_CMD;
      param_q      <= '0;
      xs_q         <= '0;
      xe_q         <= XE_RST;
      ys_q         <= '0;
      ye_q         <= YE_RST;
      x_q          <= '0;
      y_q          <= '0;
      hi_flag_q    <= 1'b0;
      hi_byte_q    <= '0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      param_q      <= param_d;
      xs_q         <= xs_d;
      xe_q         <= xe_d;
      ys_q         <= ys_d;
      ye_q         <= ye_d;
      x_q          <= x_d;
      y_q          <= y_d;
      hi_flag_q    <= hi_flag_d;
      hi_byte_q    <= hi_byte_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_data_q   <= pix_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign byte_valid   = byte_valid_q;
  assign byte_data    = byte_data_q;
  assign byte_is_data = byte_is_data_q;
  assign sync_err     = sync_err_q;
  assign pix_valid    = pix_valid_q;
  assign pix_x        = pix_x_q;
  assign pix_y        = pix_y_q;
  assign pix_data     = pix_data_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_lcd_spi_sniffer.sv
// Directed bench for lcd_spi_sniffer: drives the serial link bit by bit and checks logged strobes.
module tb_lcd_spi_sniffer;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        lcd_clk_in = 1'b0;
  logic        lcd_data_in = 1'b0;
  logic        lcd_dc_in = 1'b0;
  logic        lcd_rst_n_in = 1'b1;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_is_data;
  logic        pix_valid;
  logic [7:0]  pix_x;
  logic [7:0]  pix_y;
  logic [15:0] pix_data;
  logic        frame_done;
  logic        sync_err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  byte_log[$];
  logic        dc_log[$];
  logic [7:0]  px_log[$];
  logic [7:0]  py_log[$];
  logic [15:0] pd_log[$];
  logic        fd_log[$];
  int          sync_err_cnt = 0;
  int          frame_cnt    = 0;

  lcd_spi_sniffer dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .lcd_clk_in   (lcd_clk_in),
    .lcd_data_in  (lcd_data_in),
    .lcd_dc_in    (lcd_dc_in),
    .lcd_rst_n_in (lcd_rst_n_in),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_is_data (byte_is_data),
    .pix_valid    (pix_valid),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_data     (pix_data),
    .frame_done   (frame_done),
    .sync_err     (sync_err)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (byte_valid) begin
      byte_log.push_back(byte_data);
      dc_log.push_back(byte_is_data);
    end
    if (pix_valid) begin
      px_log.push_back(pix_x);
      py_log.push_back(pix_y);
      pd_log.push_back(pix_data);
      fd_log.push_back(frame_done);
    end
    if (sync_err) sync_err_cnt++;
    if (frame_done) frame_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_in);
  endtask

  task automatic send_bit(input logic b, input logic dc);
    lcd_data_in = b;
    lcd_dc_in   = dc;
    lcd_clk_in  = 1'b0;
    wait_clks(4);
    lcd_clk_in = 1'b1;
    wait_clks(4);
    lcd_clk_in = 1'b0;
  endtask

  task automatic send_byte(input logic dc, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i], dc);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_bv"}, {31'd0, byte_valid}, 32'd0);
    check({tag, "_bd"}, {24'd0, byte_data}, 32'd0);
    check({tag, "_bdc"}, {31'd0, byte_is_data}, 32'd0);
    check({tag, "_pv"}, {31'd0, pix_valid}, 32'd0);
    check({tag, "_px"}, {24'd0, pix_x}, 32'd0);
    check({tag, "_py"}, {24'd0, pix_y}, 32'd0);
    check({tag, "_pd"}, {16'd0, pix_data}, 32'd0);
    check({tag, "_fd"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_se"}, {31'd0, sync_err}, 32'd0);
  endtask

  initial begin
    int b0, p0, s0, f0;
    logic [7:0]  t1_data[5];
    logic        t1_dc[5];
    logic [7:0]  t2_x[6];
    logic [7:0]  t2_y[6];

    t1_data = '{8'h2A, 8'h00, 8'h05, 8'h00, 8'h07};
    t1_dc   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    t2_x    = '{8'd5, 8'd6, 8'd7, 8'd5, 8'd6, 8'd7};
    t2_y    = '{8'd2, 8'd2, 8'd2, 8'd3, 8'd3, 8'd3};

    // Reset state
    wait_clks(4);
    check_outputs_zero("reset");
    rst_in = 1'b0;
    wait_clks(4);

    // Test 1: CASET 5..7
    b0 = byte_log.size();
    for (int i = 0; i < 5; i++) send_byte(t1_dc[i], t1_data[i]);
    wait_clks(10);
    check("t1_count", byte_log.size() - b0, 5);
    if (byte_log.size() - b0 == 5) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("t1_byte%0d", i), {24'd0, byte_log[b0+i]}, {24'd0, t1_data[i]});
        check($sformatf("t1_dc%0d", i), {31'd0, dc_log[b0+i]}, {31'd0, t1_dc[i]});
      end
    end

    // Test 2: RASET 2..3, RAMWR six pixels F800
    p0 = px_log.size();
    f0 = frame_cnt;
    send_byte(1'b0, 8'h2B);
    send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h02);
    send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h03);
    send_byte(1'b0, 8'h2C);
    for (int i = 0; i < 6; i++) begin
      send_byte(1'b1, 8'hF8);
      send_byte(1'b1, 8'h00);
    end
    wait_clks(10);
    check("t2_count", px_log.size() - p0, 6);
    check("t2_frames", frame_cnt - f0, 1);
    if (px_log.size() - p0 == 6) begin
      for (int i = 0; i < 6; i++) begin
        check($sformatf("t2_x%0d", i), {24'd0, px_log[p0+i]}, {24'd0, t2_x[i]});
        check($sformatf("t2_y%0d", i), {24'd0, py_log[p0+i]}, {24'd0, t2_y[i]});
        check($sformatf("t2_d%0d", i), {16'd0, pd_log[p0+i]}, 32'h0000F800);
        check($sformatf("t2_fd%0d", i), {31'd0, fd_log[p0+i]}, (i == 5) ? 32'd1 : 32'd0);
      end
    end

    // Test 3: 5 stray bits, idle timeout, then byte 3A
    b0 = byte_log.size();
    s0 = sync_err_cnt;
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    wait_clks(100);
    check("t3_sync_err", sync_err_cnt - s0, 1);
    check("t3_no_byte", byte_log.size() - b0, 0);
    send_byte(1'b0, 8'h3A);
    wait_clks(10);
    check("t3_count", byte_log.size() - b0, 1);
    check("t3_byte", {24'd0, byte_data}, 32'h3A);
    check("t3_sync_total", sync_err_cnt - s0, 1);

    // Test 4: half pixel discarded by repeated RAMWR
    p0 = px_log.size();
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'hFF);
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'h07);
    send_byte(1'b1, 8'hE0);
    wait_clks(10);
    check("t4_count", px_log.size() - p0, 1);
    if (px_log.size() - p0 == 1) begin
      check("t4_x", {24'd0, px_log[p0]}, 32'd5);
      check("t4_y", {24'd0, py_log[p0]}, 32'd2);
      check("t4_d", {16'd0, pd_log[p0]}, 32'h07E0);
    end

    // Test 5: rst_in mid-byte and mid-frame
    send_byte(1'b1, 8'hF8);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1);
    rst_in = 1'b1;
    wait_clks(1);
    check_outputs_zero("t5_rst");
    rst_in = 1'b0;
    wait_clks(4);
    p0 = px_log.size();
    f0 = frame_cnt;
    send_byte(1'b0, 8'h2C);
    for (int i = 0; i < 9; i++) begin
      send_byte(1'b1, 8'h12);
      send_byte(1'b1, 8'(8'h30 + i));
    end
    wait_clks(10);
    check("t5_count", px_log.size() - p0, 9);
    check("t5_frames", frame_cnt - f0, 0);
    if (px_log.size() - p0 == 9) begin
      check("t5_x0", {24'd0, px_log[p0]}, 32'd0);
      check("t5_y0", {24'd0, py_log[p0]}, 32'd0);
      check("t5_d0", {16'd0, pd_log[p0]}, 32'h1230);
      check("t5_x8", {24'd0, px_log[p0+8]}, 32'd8);
      check("t5_y8", {24'd0, py_log[p0+8]}, 32'd0);
      check("t5_d8", {16'd0, pd_log[p0+8]}, 32'h1238);
    end

    // Test 6: panel reset during RAMWR
    send_byte(1'b0, 8'h2A);
    send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h03);
    send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h09);
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'hAA);
    b0 = byte_log.size();
    p0 = px_log.size();
    s0 = sync_err_cnt;
    lcd_rst_n_in = 1'b0;
    wait_clks(4);
    send_byte(1'b1, 8'h11);
    send_byte(1'b1, 8'h22);
    wait_clks(100);
    check("t6_no_bytes", byte_log.size() - b0, 0);
    check("t6_no_pix", px_log.size() - p0, 0);
    check("t6_no_sync", sync_err_cnt - s0, 0);
    lcd_rst_n_in = 1'b1;
    wait_clks(5);
    send_byte(1'b1, 8'h33);
    send_byte(1'b1, 8'h44);
    wait_clks(10);
    check("t6_bytes_after", byte_log.size() - b0, 2);
    check("t6_ignored", px_log.size() - p0, 0);
    send_byte(1'b0, 8'h2C);
    send_byte(1'b1, 8'h55);
    send_byte(1'b1, 8'h66);
    wait_clks(10);
    check("t6_count", px_log.size() - p0, 1);
    if (px_log.size() - p0 == 1) begin
      check("t6_x", {24'd0, px_log[p0]}, 32'd0);
      check("t6_y", {24'd0, py_log[p0]}, 32'd0);
      check("t6_d", {16'd0, pd_log[p0]}, 32'h5566);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
